uart_cmd_counter_ctrl: RTL and testbench

Parametrised control core for the UART/button counter display. It consumes command bytes from the Rx FIFO and single-cycle pulses from the debounced buttons, and runs an up/down wrap-around counter with a programmable tick rate. It also returns status and echo bytes to the UART transmitter through a busy/start handshake. It sits between the Rx FIFO, the button debouncers, the UART Tx and FndController, and replaces the fixed fsm_btn + upcounter pair.

---
 rtl/cnt_ctrl_pkg.sv | 31 +++
 rtl/tick_prescaler.sv | 38 +++
 rtl/uart_cmd_counter_ctrl.sv | 135 +++++++++++++
 tb/tb_uart_cmd_counter_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_ctrl_pkg.sv
// Shared command bytes, status characters and FSM encodings for the
// UART/button counter control core.
package cnt_ctrl_pkg;

  localparam logic [7:0] CMD_RUN   = 8'h72;  // 'r'
  localparam logic [7:0] CMD_STOP  = 8'h73;  // 's'
  localparam logic [7:0] CMD_GO    = 8'h67;  // 'g'
  localparam logic [7:0] CMD_CLR   = 8'h63;  // 'c'
  localparam logic [7:0] CMD_UP    = 8'h75;  // 'u'
  localparam logic [7:0] CMD_DOWN  = 8'h64;  // 'd'
  localparam logic [7:0] CMD_QUERY = 8'h3F;  // '?'

  localparam logic [7:0] ST_RUN_CHR  = 8'h52;  // 'R'
  localparam logic [7:0] ST_STOP_CHR = 8'h53;  // 'S'

  typedef enum logic {
    RS_STOP = 1'b0,
    RS_RUN  = 1'b1
  } run_state_e;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_WAIT  = 2'd1,
    TX_START = 2'd2
  } tx_state_e;

  function automatic logic [7:0] status_chr(input logic running);
    return running ? ST_RUN_CHR : ST_STOP_CHR;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Count-step prescaler: emits o_tick on the last of every TICK_DIV enabled
// cycles; holds its phase while disabled so a pause does not lose progress.
module tick_prescaler #(
  parameter int TICK_DIV = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int              PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  always_comb begin
    o_tick = i_en & (cnt_q == LAST);
    cnt_d  = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (o_tick) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_cmd_counter_ctrl.sv
// Up/down wrap-around counter driven by UART command bytes and button pulses,
// with a one-deep status/echo Tx path. Define CMD_ECHO_EN to echo non-'?' bytes.
module uart_cmd_counter_ctrl
  import cnt_ctrl_pkg::*;
#(
  parameter int CNT_W    = 14,
  parameter int CNT_MAX  = 9999,
  parameter int TICK_DIV = 10_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_valid,
  output logic             o_rx_ready,
  input  logic             i_btn_run,
  input  logic             i_btn_clr,
  input  logic             i_btn_dir,
  input  logic             i_tx_busy,
  output logic             o_tx_start,
  output logic [7:0]       o_tx_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_running,
  output logic             o_dir_down
);

  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(CNT_MAX);

  run_state_e       run_q, run_d;
  tx_state_e        tx_q, tx_d;
  logic             dir_down_q, dir_down_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       tx_data_q, tx_data_d;

  logic       accept, clear, tick, tx_push;
  logic [7:0] tx_byte;

  function automatic logic [CNT_W-1:0] step_count(input logic [CNT_W-1:0] c,
                                                  input logic down);
    if (down) return (c == '0) ? MAX_V : c - 1'b1;
    return (c == MAX_V) ? '0 : c + 1'b1;
  endfunction

  // Any button pulse blocks the FIFO pop so buttons and bytes never collide.
  assign o_rx_ready = ~(i_btn_run | i_btn_clr | i_btn_dir) & (tx_q == TX_IDLE);
  assign accept     = i_rx_valid & o_rx_ready;
  assign clear      = i_btn_clr | (accept & (i_rx_data == CMD_CLR));

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk    (clk),
    .reset  (reset),
    .i_en   (run_q == RS_RUN),
    .i_clr  (clear),
    .o_tick (tick)
  );

  always_comb begin
    tx_push = 1'b0;
    tx_byte = status_chr(run_q == RS_RUN);
    if (accept) begin
      if (i_rx_data == CMD_QUERY) begin
        tx_push = 1'b1;
      end
`ifdef CMD_ECHO_EN
      else begin
        tx_push = 1'b1;
        tx_byte = i_rx_data;
      end
`endif
    end
  end

  always_comb begin
    run_d      = run_q;
    dir_down_d = dir_down_q;
    if (i_btn_run) begin
      run_d = (run_q == RS_RUN) ? RS_STOP : RS_RUN;
    end else if (accept) begin
      case (i_rx_data)
        CMD_RUN:  run_d = (run_q == RS_RUN) ? RS_STOP : RS_RUN;
        CMD_STOP: run_d = RS_STOP;
        CMD_GO:   run_d = RS_RUN;
        default:  run_d = run_q;
      endcase
    end
    if (i_btn_dir) begin
      dir_down_d = ~dir_down_q;
    end else if (accept && (i_rx_data == CMD_UP)) begin
      dir_down_d = 1'b0;
    end else if (accept && (i_rx_data == CMD_DOWN)) begin
      dir_down_d = 1'b1;
    end

    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (tick) begin
      count_d = step_count(count_q, dir_down_q);
    end

    tx_d      = tx_q;
    tx_data_d = tx_data_q;
    case (tx_q)
      TX_IDLE: if (tx_push) begin
        tx_d      = TX_WAIT;
        tx_data_d = tx_byte;
      end
      TX_WAIT:  if (!i_tx_busy) tx_d = TX_START;
      TX_START: tx_d = TX_IDLE;
      default:  tx_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q      <= RS_STOP;
      tx_q       <= TX_IDLE;
      dir_down_q <= 1'b0;
      count_q    <= '0;
      tx_data_q  <= 8'h00;
    end else begin
      run_q      <= run_d;
      tx_q       <= tx_d;
      dir_down_q <= dir_down_d;
      count_q    <= count_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign o_tx_start = (tx_q == TX_START);
  assign o_tx_data  = tx_data_q;
  assign o_count    = count_q;
  assign o_running  = (run_q == RS_RUN);
  assign o_dir_down = dir_down_q;

endmodule

// File: tb/tb_uart_cmd_counter_ctrl.sv
// Bench for uart_cmd_counter_ctrl at TICK_DIV=4, CNT_MAX=9: vector table for
// single-cycle behaviour, hand sequences for timing corners, Tx scoreboard.
module tb_uart_cmd_counter_ctrl;
  import cnt_ctrl_pkg::*;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    i_rx_data = 8'h00;
  logic          i_rx_valid = 1'b0;
  logic          o_rx_ready;
  logic          i_btn_run = 1'b0, i_btn_clr = 1'b0, i_btn_dir = 1'b0;
  logic          i_tx_busy = 1'b0;
  logic          o_tx_start;
  logic [7:0]    o_tx_data;
  logic [CW-1:0] o_count;
  logic          o_running, o_dir_down;

  always #5 clk = ~clk;

  uart_cmd_counter_ctrl #(.CNT_W(CW), .CNT_MAX(9), .TICK_DIV(4)) dut (
    .clk(clk), .reset(reset),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready),
    .i_btn_run(i_btn_run), .i_btn_clr(i_btn_clr), .i_btn_dir(i_btn_dir),
    .i_tx_busy(i_tx_busy), .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
    .o_count(o_count), .o_running(o_running), .o_dir_down(o_dir_down)
  );

  typedef struct packed {
    logic          run, clr, dir, vld;
    logic [7:0]    data;
    logic          rdy;
    logic [CW-1:0] cnt;
    logic          running, down;
  } vec_t;

  vec_t       vecs[13];
  int         checks = 0, errors = 0, tx_pulses = 0, saved_pulses;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Tx scoreboard: every start pulse must match the oldest queued byte.
  always @(negedge clk) begin
    if (reset && o_tx_start) begin
      tx_pulses++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected: got byte %0h, expected no start", o_tx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (o_tx_data !== mon_exp) begin
          errors++;
          $display("FAIL tx_data: got %0h, expected %0h", o_tx_data, mon_exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic c, input logic d,
                       input logic v, input logic [7:0] b);
    i_btn_run  = r;
    i_btn_clr  = c;
    i_btn_dir  = d;
    i_rx_valid = v;
    i_rx_data  = b;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic send(input logic [7:0] b);
    drive(1'b0, 1'b0, 1'b0, 1'b1, b);
    step();
    idle();
  endtask

  task automatic wait_count(input int v, input int max);
    int n = 0;
    while (int'(o_count) != v && n < max) begin
      step();
      n++;
    end
    chk("wait_count", int'(o_count), v);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish, expected $finish");
    $fatal(1);
  end

  initial begin
    //                run   clr   dir   vld   data      rdy   cnt   run   down
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, CMD_DOWN, 1'b1, 4'd0, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, CMD_UP,   1'b1, 4'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00,    1'b0, 4'd0, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, CMD_GO,   1'b0, 4'd0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, CMD_GO,   1'b1, 4'd0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00,    1'b1, 4'd0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, CMD_STOP, 1'b1, 4'd0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00,    1'b1, 4'd0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00,    1'b0, 4'd0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00,    1'b1, 4'd0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00,    1'b1, 4'd1, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, CMD_RUN,  1'b1, 4'd1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, CMD_CLR,  1'b1, 4'd0, 1'b0, 1'b0};

    // reset values
    step(); step();
    chk("rst_count", int'(o_count), 0);
    chk("rst_running", int'(o_running), 0);
    chk("rst_dir", int'(o_dir_down), 0);
    chk("rst_tx_start", int'(o_tx_start), 0);
    chk("rst_tx_data", int'(o_tx_data), 0);
    chk("rst_rx_ready", int'(o_rx_ready), 1);
    reset = 1'b1;
    step();

    // single-cycle vectors; rows 7..10 also check that a pause keeps prescaler phase
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].run, vecs[i].clr, vecs[i].dir, vecs[i].vld, vecs[i].data);
      #1;
      chk($sformatf("vec%0d_rdy", i), int'(o_rx_ready), int'(vecs[i].rdy));
      step();
      chk($sformatf("vec%0d_cnt", i), int'(o_count), int'(vecs[i].cnt));
      chk($sformatf("vec%0d_run", i), int'(o_running), int'(vecs[i].running));
      chk($sformatf("vec%0d_dir", i), int'(o_dir_down), int'(vecs[i].down));
    end
    idle();

    // 40 cycles of RUN: one step per 4 cycles, 9->0 wrap at the end
    send(CMD_GO);
    chk("runA_k0", int'(o_count), 0);
    for (int k = 1; k <= 40; k++) begin
      step();
      chk($sformatf("runA_k%0d", k), int'(o_count), (k / 4) % 10);
    end
    chk("runA_running", int'(o_running), 1);

    // down from 0 wraps to 9, then up from 9 wraps to 0
    send(CMD_DOWN);
    chk("dn_dir", int'(o_dir_down), 1);
    step(); step();
    chk("dn_before", int'(o_count), 0);
    step();
    chk("dn_wrap", int'(o_count), 9);
    send(CMD_UP);
    step(); step();
    chk("up_before", int'(o_count), 9);
    step();
    chk("up_wrap", int'(o_count), 0);
    send(CMD_STOP);

    // '?' in STOP while Tx is busy for 5 cycles
    i_tx_busy = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b1, CMD_QUERY);
    #1;
    chk("q_rdy_accept", int'(o_rx_ready), 1);
    exp_q.push_back(ST_STOP_CHR);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b1, CMD_GO);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("q_busy%0d_rdy", k), int'(o_rx_ready), 0);
      chk($sformatf("q_busy%0d_start", k), int'(o_tx_start), 0);
      step();
    end
    i_tx_busy = 1'b0;
    #1;
    chk("q_drop_rdy", int'(o_rx_ready), 0);
    chk("q_drop_start", int'(o_tx_start), 0);
    step();
    chk("q_start", int'(o_tx_start), 1);
    chk("q_start_rdy", int'(o_rx_ready), 0);
    idle();
    step();
    chk("q_after_start", int'(o_tx_start), 0);
    chk("q_after_rdy", int'(o_rx_ready), 1);
    chk("q_not_popped", int'(o_running), 0);
    chk("q_pulses", tx_pulses, 1);

    // clr + run together from count 5 in STOP; concurrent byte must stay in FIFO
    send(CMD_CLR);
    send(CMD_GO);
    wait_count(5, 40);
    send(CMD_STOP);
    chk("cr_count5", int'(o_count), 5);
    drive(1'b1, 1'b1, 1'b0, 1'b1, CMD_STOP);
    #1;
    chk("cr_rdy", int'(o_rx_ready), 0);
    step();
    idle();
    chk("cr_count", int'(o_count), 0);
    chk("cr_running", int'(o_running), 1);

    // clear in the same cycle as a tick: clear wins, phase restarts
    step(); step(); step();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step();
    idle();
    chk("ct_count", int'(o_count), 0);
    step(); step(); step();
    chk("ct_before", int'(o_count), 0);
    step();
    chk("ct_step", int'(o_count), 1);
    send(CMD_STOP);
    send(CMD_CLR);

    // unlisted byte: consumed, no state change, echoed only with CMD_ECHO_EN
`ifdef CMD_ECHO_EN
    exp_q.push_back(8'h78);
`endif
    send(8'h78);
    chk("x_count", int'(o_count), 0);
    chk("x_running", int'(o_running), 0);
    chk("x_dir", int'(o_dir_down), 0);
    step(); step(); step(); step();
`ifdef CMD_ECHO_EN
    chk("x_pulses", tx_pulses, 2);
`else
    chk("x_pulses", tx_pulses, 1);
`endif

    // reset in TX_WAIT with count 7 drops the pending byte
    send(CMD_GO);
    wait_count(7, 60);
    send(CMD_STOP);
    chk("rs_count7", int'(o_count), 7);
    send(CMD_DOWN);
    i_tx_busy = 1'b1;
    send(CMD_QUERY);
    step();
    chk("rs_in_wait", int'(o_rx_ready), 0);
    chk("rs_data_loaded", int'(o_tx_data), int'(ST_STOP_CHR));
    saved_pulses = tx_pulses;
    reset = 1'b0;
    #1;
    chk("rs_count", int'(o_count), 0);
    chk("rs_running", int'(o_running), 0);
    chk("rs_dir", int'(o_dir_down), 0);
    chk("rs_start", int'(o_tx_start), 0);
    chk("rs_data", int'(o_tx_data), 0);
    chk("rs_rdy", int'(o_rx_ready), 1);
    step(); step();
    reset = 1'b1;
    i_tx_busy = 1'b0;
    for (int k = 0; k < 6; k++) step();
    chk("rs_no_start", tx_pulses, saved_pulses);
    chk("rs_rdy_after", int'(o_rx_ready), 1);

    chk("tx_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
